// File: rtl/shift_chain_pkg.sv
// Shared types and constants for the shift_chain block.
package shift_chain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/shift_stage.sv
// One WIDTH-bit chain stage: hold, parallel load or shift-in, async active-high reset.
module shift_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             sh_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic [WIDTH-1:0] sh_data_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld_i)      q_d = ld_data_i;
    else if (sh_i) q_d = sh_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_chain.sv
// DEPTH x WIDTH shift chain with parallel load and counted shift command.
// Define SHIFT_CHAIN_ROTATE_EN to enable rotate mode via rot.
module shift_chain
  import shift_chain_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AMT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DEPTH*WIDTH-1:0] data,
  input  logic [WIDTH-1:0]       ser_in,
  input  logic                   start,
  input  logic                   dir,
  input  logic                   rot,
  input  logic [AMT_W-1:0]       amount,
  output logic                   busy,
  output logic                   done,
  output logic [DEPTH*WIDTH-1:0] right,
  output logic [WIDTH-1:0]       ser_out
);

  state_e                        state_q, state_d;
  logic [AMT_W-1:0]              cnt_q, cnt_d;
  logic                          dir_q, dir_d;
  logic                          done_q, done_d;
  logic [WIDTH-1:0]              ser_q, ser_d;
  logic                          ld_en, sh_en;
  logic [WIDTH-1:0]              leave, fill;
  logic [DEPTH-1:0][WIDTH-1:0]   stage_q, shin, data_v;

  assign data_v = data;
  assign leave  = (dir_q == DIR_UP) ? stage_q[DEPTH-1] : stage_q[0];

`ifdef SHIFT_CHAIN_ROTATE_EN
  logic rot_q, rot_d;
  assign fill = rot_q ? leave : ser_in;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign fill       = ser_in;
`endif

  // Neighbour selection per stage; end stages take the fill word.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] from_lo, from_hi;
    if (i == 0) begin : g_lo_end
      assign from_lo = fill;
    end else begin : g_lo_mid
      assign from_lo = stage_q[i-1];
    end
    if (i == DEPTH-1) begin : g_hi_end
      assign from_hi = fill;
    end else begin : g_hi_mid
      assign from_hi = stage_q[i+1];
    end
    assign shin[i] = (dir_q == DIR_UP) ? from_lo : from_hi;

    shift_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ld_i      (ld_en),
      .sh_i      (sh_en),
      .ld_data_i (data_v[i]),
      .sh_data_i (shin[i]),
      .q_o       (stage_q[i])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    ser_d   = ser_q;
    ld_en   = 1'b0;
    sh_en   = 1'b0;
`ifdef SHIFT_CHAIN_ROTATE_EN
    rot_d   = rot_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          ld_en = 1'b1;
        end else if (start) begin
          dir_d = dir;
`ifdef SHIFT_CHAIN_ROTATE_EN
          rot_d = rot;
`endif
          if (amount == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = amount;
          end
        end
      end
      SHIFT: begin
        sh_en = 1'b1;
        ser_d = leave;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      ser_q   <= '0;
`ifdef SHIFT_CHAIN_ROTATE_EN
      rot_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      ser_q   <= ser_d;
`ifdef SHIFT_CHAIN_ROTATE_EN
      rot_q   <= rot_d;
`endif
    end
  end

  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign right   = stage_q;
  assign ser_out = ser_q;

endmodule

// File: tb/tb_shift_chain.sv
// Directed self-checking bench for shift_chain (WIDTH=8, DEPTH=4, AMT_W=4).
module tb_shift_chain;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic [7:0]  ser_in;
  logic        start;
  logic        dir;
  logic        rot;
  logic [3:0]  amount;
  logic        busy;
  logic        done;
  logic [31:0] right;
  logic [7:0]  ser_out;

  int total = 0;
  int bad   = 0;

  shift_chain #(.WIDTH(8), .DEPTH(4), .AMT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .data    (data),
    .ser_in  (ser_in),
    .start   (start),
    .dir     (dir),
    .rot     (rot),
    .amount  (amount),
    .busy    (busy),
    .done    (done),
    .right   (right),
    .ser_out (ser_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".right"},   right,          32'h0);
    check({tag, ".ser_out"}, {24'h0, ser_out}, 32'h0);
    check({tag, ".busy"},    {31'h0, busy},  32'h0);
    check({tag, ".done"},    {31'h0, done},  32'h0);
  endtask

  logic [31:0] rot_exp;

  initial begin
`ifdef SHIFT_CHAIN_ROTATE_EN
    rot_exp = 32'h11443322;
`else
    rot_exp = 32'hAA443322;
`endif
    rst = 1'b1; load = 0; data = '0; ser_in = '0;
    start = 0; dir = 0; rot = 0; amount = '0;
    #2;
    check_idle_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // parallel load
    load = 1; data = 32'h44332211;
    tick();
    load = 0;
    check("load.right", right, 32'h44332211);
    check("load.done",  {31'h0, done}, 32'h0);
    check("load.busy",  {31'h0, busy}, 32'h0);

    // up fill, amount 2; command inputs wiggle while busy and must be ignored
    start = 1; dir = 0; rot = 0; amount = 4'd2; ser_in = 8'hAA;
    tick();
    start = 0; dir = 1; amount = 4'd7; rot = 1;
    check("up2.busy0", {31'h0, busy}, 32'h1);
    check("up2.done0", {31'h0, done}, 32'h0);
    tick();
    check("up2.busy1",  {31'h0, busy}, 32'h1);
    check("up2.right1", right, 32'h332211AA);
    check("up2.ser1",   {24'h0, ser_out}, 32'h44);
    tick();
    check("up2.busy2",  {31'h0, busy}, 32'h0);
    check("up2.done2",  {31'h0, done}, 32'h1);
    check("up2.right2", right, 32'h2211AAAA);
    check("up2.ser2",   {24'h0, ser_out}, 32'h33);

    // back-to-back load in the done cycle; ser_out must not change
    load = 1; data = 32'h44332211;
    tick();
    load = 0;
    check("b2b.right", right, 32'h44332211);
    check("b2b.done",  {31'h0, done}, 32'h0);
    check("b2b.ser",   {24'h0, ser_out}, 32'h33);

    // down, rot=1, amount 1
    start = 1; dir = 1; rot = 1; amount = 4'd1; ser_in = 8'hAA;
    tick();
    start = 0; rot = 0;
    check("dn1.busy", {31'h0, busy}, 32'h1);
    tick();
    check("dn1.done",  {31'h0, done}, 32'h1);
    check("dn1.busy2", {31'h0, busy}, 32'h0);
    check("dn1.right", right, rot_exp);
    check("dn1.ser",   {24'h0, ser_out}, 32'h11);

    // amount 0 issued in the done cycle
    start = 1; dir = 0; amount = 4'd0;
    tick();
    start = 0;
    check("amt0.done",  {31'h0, done}, 32'h1);
    check("amt0.busy",  {31'h0, busy}, 32'h0);
    check("amt0.right", right, rot_exp);
    tick();
    check("amt0.done2", {31'h0, done}, 32'h0);
    check("amt0.busy2", {31'h0, busy}, 32'h0);

    // load and start together: load wins, no done
    load = 1; start = 1; amount = 4'd3; data = 32'h0A0B0C0D;
    tick();
    load = 0; start = 0;
    check("ldst.right", right, 32'h0A0B0C0D);
    check("ldst.done",  {31'h0, done}, 32'h0);
    check("ldst.busy",  {31'h0, busy}, 32'h0);
    tick();
    check("ldst.done2", {31'h0, done}, 32'h0);

    // amount 5 > DEPTH, load while busy ignored, reset after 2 steps
    load = 1; data = 32'h44332211;
    tick();
    load = 0;
    start = 1; dir = 0; amount = 4'd5; ser_in = 8'h5A;
    tick();
    start = 0;
    load = 1; data = 32'hFFFFFFFF;
    tick();
    load = 0;
    tick();
    check("abort.busy",  {31'h0, busy}, 32'h1);
    check("abort.right", right, 32'h22115A5A);
    check("abort.ser",   {24'h0, ser_out}, 32'h33);
    #2;
    rst = 1'b1;
    #1;
    check_idle_zero("abort");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort.nodone", {31'h0, done}, 32'h0);
    end

    // accepted again after reset
    load = 1; data = 32'h12345678;
    tick();
    load = 0;
    check("post.load", right, 32'h12345678);
    start = 1; dir = 0; amount = 4'd1; ser_in = 8'h99;
    tick();
    start = 0;
    check("post.busy", {31'h0, busy}, 32'h1);
    tick();
    check("post.right", right, 32'h34567899);
    check("post.ser",   {24'h0, ser_out}, 32'h12);
    check("post.done",  {31'h0, done}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
